// File: rtl/dilithium_modmul_pipe.sv
// Pipelined modular multiplier, (opt1*opt2) mod q for q = 2^23 - 2^13 + 1.
// Free-running datapath; valid_in travels a parallel shift register and
// drives the occupancy counter used by the NTT controller to detect drain.
// Optional macro MODMUL_RANGECHK_EN adds range_err, flagging pairs whose
// operand was >= PARAM_Q.
module dilithium_modmul_pipe #(
  parameter logic [22:0]  PARAM_Q = 23'd8380417,
  parameter int unsigned  LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [22:0] opt1,
  input  logic [22:0] opt2,
  input  logic        valid_in,
  output logic [22:0] mul_result,
  output logic        valid_out,
  output logic [3:0]  in_flight,
  output logic        idle
`ifdef MODMUL_RANGECHK_EN
  , output logic      range_err
`endif
);

  // Registers after fold 3; the final subtract feeds this delay tail.
  localparam int unsigned TAIL = LATENCY - 6;
  // 2^23 == 2^13 - 1 (mod q), so each fold multiplies the high part by 8191.
  localparam logic [12:0] FOLD_K = 13'd8191;

  logic [22:0]        a_q, a_d, b_q, b_d;
  logic [34:0]        pp_lo_q, pp_lo_d;
  logic [33:0]        pp_hi_q, pp_hi_d;
  logic [45:0]        p_q, p_d;
  logic [36:0]        r1_q, r1_d;
  logic [27:0]        r2_q, r2_d;
  logic [23:0]        r3_q, r3_d;
  logic [22:0]        r4_c;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [3:0]         in_flight_q, in_flight_d;
  logic               idle_q, idle_d;

  // Datapath stages, valid shift register and occupancy counter next-state.
  always_comb begin
    a_d      = opt1;
    b_d      = opt2;
    pp_lo_d  = 35'(a_q) * 35'(b_q[11:0]);
    pp_hi_d  = 34'(a_q) * 34'(b_q[22:12]);
    p_d      = 46'(pp_lo_q) + (46'(pp_hi_q) << 12);
    r1_d     = 37'(p_q[22:0])  + 37'(p_q[45:23])  * 37'(FOLD_K);
    r2_d     = 28'(r1_q[22:0]) + 28'(r1_q[36:23]) * 28'(FOLD_K);
    r3_d     = 24'(r2_q[22:0]) + 24'(r2_q[27:23]) * 24'(FOLD_K);
    vld_d    = {vld_q[LATENCY-2:0], valid_in};
    in_flight_d = in_flight_q;
    if (valid_in && !vld_q[LATENCY-1]) begin
      in_flight_d = in_flight_q + 4'd1;
    end else if (!valid_in && vld_q[LATENCY-1]) begin
      in_flight_d = in_flight_q - 4'd1;
    end
    idle_d = (in_flight_d == 4'd0);
  end

  // Final conditional subtract; r3 < 2q so one subtract fully reduces.
  assign r4_c = (r3_q >= 24'(PARAM_Q)) ? 23'(r3_q - 24'(PARAM_Q)) : 23'(r3_q);

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      pp_lo_q     <= '0;
      pp_hi_q     <= '0;
      p_q         <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      vld_q       <= '0;
      in_flight_q <= '0;
      idle_q      <= 1'b1;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      pp_lo_q     <= pp_lo_d;
      pp_hi_q     <= pp_hi_d;
      p_q         <= p_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      vld_q       <= vld_d;
      in_flight_q <= in_flight_d;
      idle_q      <= idle_d;
    end
  end

  generate
    if (TAIL == 0) begin : g_no_tail
      assign mul_result = r4_c;
    end else begin : g_tail
      logic [22:0] tail_q [TAIL];
      logic [22:0] tail_d [TAIL];

      // Delay tail: first stage holds the reduced result, rest pure delay.
      always_comb begin
        tail_d[0] = r4_c;
        for (int i = 1; i < int'(TAIL); i++) begin
          tail_d[i] = tail_q[i-1];
        end
      end

      // Delay tail registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(TAIL); i++) begin
            tail_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < int'(TAIL); i++) begin
            tail_q[i] <= tail_d[i];
          end
        end
      end

      assign mul_result = tail_q[TAIL-1];
    end
  endgenerate

  assign valid_out = vld_q[LATENCY-1];
  assign in_flight = in_flight_q;
  assign idle      = idle_q;

`ifdef MODMUL_RANGECHK_EN
  logic [LATENCY-1:0] rng_q, rng_d;

  // Out-of-range flag of each valid pair, aligned with valid_out.
  always_comb begin
    rng_d = {rng_q[LATENCY-2:0],
             valid_in && ((opt1 >= PARAM_Q) || (opt2 >= PARAM_Q))};
  end

  // Range flag shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_q <= '0;
    end else begin
      rng_q <= rng_d;
    end
  end

  assign range_err = rng_q[LATENCY-1];
`endif

endmodule
